// File: rtl/uart_fifo_mmio_if.sv
// Single-cycle MMIO bus bundle between the core (master) and the LED/UART peripheral (slave).
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface uart_fifo_mmio_if;
  logic              mmio_req;
  logic              mmio_we;
  logic [`ADDR_W-1:0] mmio_addr;
  logic [`XLEN-1:0]   mmio_wdata;
  logic [`XLEN-1:0]   mmio_rdata;
  logic              mmio_ready;

  modport master (output mmio_req, mmio_we, mmio_addr, mmio_wdata,
                  input  mmio_rdata, mmio_ready);
  modport slave  (input  mmio_req, mmio_we, mmio_addr, mmio_wdata,
                  output mmio_rdata, mmio_ready);
endinterface

// File: rtl/uart_fifo_mmio.sv
// LED register plus UART with TX/RX FIFOs, programmable divisor and sticky W1C error flags.
// Optional macro UART_LOOPBACK_EN adds CTRL bit0 routing uart_tx back into the receiver.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef IO_LED_WIDTH
`define IO_LED_WIDTH 8
`endif
`ifndef UART_DIV
`define UART_DIV 16
`endif

module uart_fifo_mmio #(
  parameter logic [`ADDR_W-1:0] BASE_ADDR = `IO_BASE_ADDR,
  parameter int LED_W    = `IO_LED_WIDTH,
  parameter int UART_DIV = `UART_DIV,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_fifo_mmio_if.slave  bus,
  output logic [LED_W-1:0] led_out,
  output logic             uart_tx,
  input  logic             uart_rx
);
  localparam int AW  = `ADDR_W;
  localparam int XL  = `XLEN;
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXP = TXA + 1;
  localparam int RXP = RXA + 1;
  localparam logic [15:0] DIV_RST = (UART_DIV < 2) ? 16'd2 : 16'(UART_DIV);

  logic [AW-1:0] off;
  assign off = bus.mmio_addr - BASE_ADDR;
  logic wr, rd;
  assign wr = bus.mmio_req &&  bus.mmio_we;
  assign rd = bus.mmio_req && !bus.mmio_we;
  logic wr_led, wr_tx, wr_stat, wr_div, rd_led, rd_stat, rd_rx, rd_div;
  assign wr_led  = wr && off == AW'(0);
  assign wr_tx   = wr && off == AW'(4);
  assign wr_stat = wr && off == AW'(8);
  assign wr_div  = wr && off == AW'(16);
  assign rd_led  = rd && off == AW'(0);
  assign rd_stat = rd && off == AW'(8);
  assign rd_rx   = rd && off == AW'(12);
  assign rd_div  = rd && off == AW'(16);
  assign bus.mmio_ready = bus.mmio_req;

  logic [LED_W-1:0] led_q;
  logic [15:0]      div_q, div_wr;
  logic             ovr_q, ferr_q, ovf_q;
  assign div_wr = (bus.mmio_wdata[15:0] < 16'd2) ? 16'd2 : bus.mmio_wdata[15:0];

  // ---------------- TX FIFO and shifter ----------------
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXA:0] tx_wp_q, tx_rp_q;
  logic         tx_empty, tx_full, tx_pop, tx_push, tx_last;
  logic         tx_act_q, tx_q;
  logic [8:0]   tx_sh_q;
  logic [3:0]   tx_bit_q;
  logic [15:0]  tx_cnt_q, tx_div_q;

  assign tx_empty = tx_wp_q == tx_rp_q;
  assign tx_full  = (tx_wp_q[TXA] != tx_rp_q[TXA]) && (tx_wp_q[TXA-1:0] == tx_rp_q[TXA-1:0]);
  assign tx_last  = tx_act_q && tx_cnt_q == 16'd0 && tx_bit_q == 4'd9;
  // Reloading on the last cycle of a stop bit keeps consecutive frames gapless.
  assign tx_pop   = !tx_empty && (!tx_act_q || tx_last);
  assign tx_push  = wr_tx && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TXA-1:0]] <= bus.mmio_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_act_q <= 1'b0;
      tx_q     <= 1'b1;
      tx_sh_q  <= '0;
      tx_bit_q <= '0;
      tx_cnt_q <= '0;
      tx_div_q <= DIV_RST;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TXP'(1);
      if (tx_pop) begin
        tx_rp_q  <= tx_rp_q + TXP'(1);
        tx_act_q <= 1'b1;
        tx_q     <= 1'b0;
        tx_sh_q  <= {1'b1, tx_mem[tx_rp_q[TXA-1:0]]};
        tx_bit_q <= '0;
        tx_cnt_q <= div_q - 16'd1;
        tx_div_q <= div_q;
      end else if (tx_act_q) begin
        if (tx_cnt_q != 16'd0) begin
          tx_cnt_q <= tx_cnt_q - 16'd1;
        end else if (tx_bit_q == 4'd9) begin
          tx_act_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          tx_q     <= tx_sh_q[0];
          tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
          tx_cnt_q <= tx_div_q - 16'd1;
        end
      end
    end
  end
  assign uart_tx = tx_q;

  // ---------------- RX synchroniser and receiver ----------------
  logic rx_in;
`ifdef UART_LOOPBACK_EN
  logic ctrl_q;
  logic wr_ctrl, rd_ctrl;
  assign wr_ctrl = wr && off == AW'(20);
  assign rd_ctrl = rd && off == AW'(20);
  assign rx_in   = ctrl_q ? tx_q : uart_rx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ctrl_q <= 1'b0;
    else if (wr_ctrl) ctrl_q <= bus.mmio_wdata[0];
  end
`else
  assign rx_in = uart_rx;
`endif

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t   rx_state_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_push_q, rx_ferr_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RST;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_state_q <= RX_START;
          rx_div_q   <= div_q;
          rx_cnt_q   <= (div_q >> 1) - 16'd1;
        end
        RX_START: if (rx_cnt_q != 16'd0) rx_cnt_q <= rx_cnt_q - 16'd1;
                  else if (rx_s2_q) rx_state_q <= RX_IDLE;
                  else begin
                    rx_state_q <= RX_DATA;
                    rx_cnt_q   <= rx_div_q - 16'd1;
                    rx_bit_q   <= '0;
                  end
        RX_DATA: if (rx_cnt_q != 16'd0) rx_cnt_q <= rx_cnt_q - 16'd1;
                 else begin
                   rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                   rx_cnt_q <= rx_div_q - 16'd1;
                   if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                   else rx_bit_q <= rx_bit_q + 3'd1;
                 end
        RX_STOP: if (rx_cnt_q != 16'd0) rx_cnt_q <= rx_cnt_q - 16'd1;
                 else if (rx_s2_q) begin
                   rx_push_q  <= 1'b1;
                   rx_state_q <= RX_IDLE;
                 end else begin
                   rx_ferr_q  <= 1'b1;
                   rx_state_q <= RX_WAIT;
                 end
        RX_WAIT: if (rx_s2_q) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RXA:0] rx_wp_q, rx_rp_q;
  logic         rx_empty, rx_full, rx_pop, rx_push;
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign rx_full  = (rx_wp_q[RXA] != rx_rp_q[RXA]) && (rx_wp_q[RXA-1:0] == rx_rp_q[RXA-1:0]);
  assign rx_pop   = rd_rx && !rx_empty;
  assign rx_push  = rx_push_q && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q[RXA-1:0]] <= rx_sh_q;
  end

  // Sticky flags: a set event in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      led_q   <= '0;
      div_q   <= DIV_RST;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + RXP'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RXP'(1);
      if (wr_led)  led_q   <= bus.mmio_wdata[LED_W-1:0];
      if (wr_div)  div_q   <= div_wr;
      ovr_q  <= (rx_push_q && rx_full && !rx_pop) || (ovr_q && !(wr_stat && bus.mmio_wdata[3]));
      ferr_q <= rx_ferr_q || (ferr_q && !(wr_stat && bus.mmio_wdata[4]));
      ovf_q  <= (wr_tx && tx_full && !tx_pop) || (ovf_q && !(wr_stat && bus.mmio_wdata[5]));
    end
  end
  assign led_out = led_q;

  logic [XL-1:0] rdata;
  always_comb begin
    rdata = '0;
    if (rd_led)  rdata[LED_W-1:0] = led_q;
    if (rd_stat) rdata[5:0] = {ovf_q, ferr_q, ovr_q, !rx_empty, tx_full, !tx_empty || tx_act_q};
    if (rd_rx && !rx_empty) rdata[7:0] = rx_mem[rx_rp_q[RXA-1:0]];
    if (rd_div)  rdata[15:0] = div_q;
`ifdef UART_LOOPBACK_EN
    if (rd_ctrl) rdata[0] = ctrl_q;
`endif
  end
  assign bus.mmio_rdata = rdata;

  logic unused_wdata;
  assign unused_wdata = ^bus.mmio_wdata;
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Randomised self-checking bench for uart_fifo_mmio: register access, TX framing, RX decoding, flags.
`timescale 1ns/1ps
module tb_uart_fifo_mmio;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int LEDW = 8, RST_DIV = 16, TXD = 8, RXD = 8;
  localparam logic [31:0] A_LED = BASE, A_TX = BASE + 4, A_STAT = BASE + 8, A_RX = BASE + 12,
                          A_DIV = BASE + 16, A_CTRL = BASE + 20, A_BAD = BASE + 24;

  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, uart_tx;
  logic [LEDW-1:0] led_out;
  uart_fifo_mmio_if bus();

  uart_fifo_mmio #(.BASE_ADDR(BASE), .LED_W(LEDW), .UART_DIV(RST_DIV),
                   .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .led_out(led_out), .uart_tx(uart_tx), .uart_rx(uart_rx));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [9:0] mon_q[$];
  int         mon_divq[$];
  bit         mon_en = 1'b0;

  task automatic step(); @(posedge clk); #1; endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mmio_req = 1'b1; bus.mmio_we = 1'b1; bus.mmio_addr = a; bus.mmio_wdata = d;
    step();
    bus.mmio_req = 1'b0; bus.mmio_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.mmio_req = 1'b1; bus.mmio_we = 1'b0; bus.mmio_addr = a;
    #1 d = bus.mmio_rdata;
    step();
    bus.mmio_req = 1'b0;
  endtask

  // Serial line driver: start bit, 8 data bits LSB first, chosen stop bit.
  task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rx = f[k];
      repeat (div) step();
    end
    uart_rx = 1'b1;
  endtask

  // Line monitor: samples every bit at its midpoint using the divisor the test expects per frame.
  always begin
    logic [9:0] fr;
    int l, off;
    step();
    if (mon_en && uart_tx === 1'b0) begin
      l = (mon_divq.size() > 0) ? mon_divq.pop_front() : 4;
      off = 0;
      for (int k = 0; k < 10; k++) begin
        repeat (k * l + l / 2 - off) step();
        off = k * l + l / 2;
        fr[k] = uart_tx;
      end
      repeat (l - l / 2 - 1) step();
      mon_q.push_back(fr);
    end
  end

  task automatic wait_frames(input int n, input int bound);
    int t;
    t = 0;
    while (mon_q.size() < n && t < bound) begin step(); t++; end
    checks++;
    if (mon_q.size() < n) begin
      errors++; $display("FAIL tx_frame_timeout: got %0d frames want %0d", mon_q.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.mmio_req = 1'b0; bus.mmio_we = 1'b0; bus.mmio_addr = '0; bus.mmio_wdata = '0;
    rst_n = 1'b0; repeat (3) step(); rst_n = 1'b1; step();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++; if (led_out !== '0) begin errors++; $display("FAIL reset_led_out: got %h want 0", led_out); end
    checks++; if (bus.mmio_ready !== 1'b0 || bus.mmio_rdata !== '0) begin
      errors++; $display("FAIL idle_bus: ready %b rdata %h want 0/0", bus.mmio_ready, bus.mmio_rdata); end
    bus.mmio_req = 1'b1; bus.mmio_addr = A_DIV; #1;
    checks++; if (bus.mmio_ready !== 1'b1) begin errors++; $display("FAIL ready: got %b want 1", bus.mmio_ready); end
    bus.mmio_req = 1'b0; step();
    rd(A_LED, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_led: got %h want 0", d); end
    rd(A_STAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_stat: got %h want 0", d); end
    rd(A_DIV, d);  checks++; if (d !== RST_DIV) begin errors++; $display("FAIL reset_div: got %h want %h", d, RST_DIV); end
    rd(A_RX, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rx: got %h want 0", d); end
    rd(A_CTRL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
    rd(A_BAD, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h want 0", d); end
    $display("reset: registers read back");
  endtask

  task automatic test_led();
    logic [31:0] v, d;
    for (int i = 0; i < 5; i++) begin
      v = $urandom;
      wr(A_LED, v);
      checks++; if (led_out !== v[LEDW-1:0]) begin errors++; $display("FAIL led_out: got %h want %h", led_out, v[LEDW-1:0]); end
      rd(A_LED, d);
      checks++; if (d !== {24'h0, v[7:0]}) begin errors++; $display("FAIL led_rd: got %h want %h", d, {24'h0, v[7:0]}); end
      $display("led write %h -> %h", v, d);
    end
    wr(A_BAD, ~v); wr(BASE - 4, ~v);
    checks++; if (led_out !== v[LEDW-1:0]) begin errors++; $display("FAIL unmapped_wr: got %h want %h", led_out, v[LEDW-1:0]); end
  endtask

  task automatic test_div();
    logic [31:0] vals[6];
    logic [31:0] d, e;
    vals = '{32'h0, 32'h1, 32'h2, 32'h3, 32'hABCD_1234, 32'h0};
    vals[5] = $urandom;
    foreach (vals[i]) begin
      wr(A_DIV, vals[i]);
      e = (vals[i][15:0] < 2) ? 32'd2 : {16'h0, vals[i][15:0]};
      rd(A_DIV, d);
      checks++; if (d !== e) begin errors++; $display("FAIL div_rd: wrote %h got %h want %h", vals[i], d, e); end
      $display("div write %h -> %h", vals[i], d);
    end
  endtask

  task automatic test_tx_frame();
    logic [9:0] f;
    logic [31:0] d;
    mon_en = 1'b0;
    wr(A_DIV, 4);
    f = {1'b1, 8'h55, 1'b0};
    wr(A_TX, 32'h55);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_push_edge: got %b want 1", uart_tx); end
    for (int n = 1; n <= 40; n++) begin
      if (n == 20) begin
        rd(A_STAT, d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL tx_busy_mid: got %h want bit0 set", d); end
      end else step();
      checks++; if (uart_tx !== f[(n - 1) / 4]) begin
        errors++; $display("FAIL tx_bit cycle %0d: got %b want %b", n, uart_tx, f[(n - 1) / 4]); end
    end
    step();
    rd(A_STAT, d);
    checks++; if (d !== 32'h0 || uart_tx !== 1'b1) begin
      errors++; $display("FAIL tx_done: stat %h tx %b want 0/1", d, uart_tx); end
    $display("tx frame 0x55 at div 4 checked");
  endtask

  task automatic test_tx_random();
    logic [7:0] b;
    int div;
    mon_en = 1'b1; mon_q.delete(); mon_divq.delete();
    for (int i = 0; i < 4; i++) begin
      repeat (12) step();
      div = $urandom_range(2, 7);
      b = 8'($urandom);
      wr(A_DIV, div);
      mon_divq.push_back(div);
      wr(A_TX, {24'h0, b});
      wait_frames(1, 12 * div + 20);
      if (mon_q.size() > 0) begin
        checks++; if (mon_q[0] !== {1'b1, b, 1'b0}) begin
          errors++; $display("FAIL tx_rand: got %b want %b", mon_q[0], {1'b1, b, 1'b0}); end
        $display("tx byte %h div %0d frame %b", b, div, mon_q[0]);
        void'(mon_q.pop_front());
      end
    end
  endtask

  task automatic test_div_midframe();
    logic [7:0] b0, b1;
    repeat (12) step();
    mon_q.delete(); mon_divq.delete();
    wr(A_DIV, 4);
    b0 = 8'($urandom); b1 = 8'($urandom);
    mon_divq.push_back(4); mon_divq.push_back(6);
    wr(A_TX, {24'h0, b0});
    wr(A_DIV, 6);
    wr(A_TX, {24'h0, b1});
    wait_frames(2, 200);
    if (mon_q.size() >= 2) begin
      checks++; if (mon_q[0] !== {1'b1, b0, 1'b0}) begin errors++; $display("FAIL div_old_frame: got %b want %b", mon_q[0], {1'b1, b0, 1'b0}); end
      checks++; if (mon_q[1] !== {1'b1, b1, 1'b0}) begin errors++; $display("FAIL div_new_frame: got %b want %b", mon_q[1], {1'b1, b1, 1'b0}); end
      $display("div change mid-frame: %h at 4, %h at 6", b0, b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    logic [31:0] d;
    logic [7:0] b;
    repeat (12) step();
    mon_q.delete(); mon_divq.delete();
    wr(A_DIV, 4);
    for (int i = 0; i < TXD + 2; i++) begin
      b = 8'($urandom);
      if (i < TXD + 1) begin sent.push_back(b); mon_divq.push_back(4); end
      wr(A_TX, {24'h0, b});
    end
    rd(A_STAT, d);
    checks++; if (d !== 32'h23) begin errors++; $display("FAIL tx_overflow_stat: got %h want 23", d); end
    wr(A_STAT, 32'h1F);
    rd(A_STAT, d);
    checks++; if (d !== 32'h23) begin errors++; $display("FAIL w1c_other_bits: got %h want 23", d); end
    wr(A_STAT, 32'h20);
    rd(A_STAT, d);
    checks++; if (d !== 32'h03) begin errors++; $display("FAIL w1c_overflow: got %h want 03", d); end
    wait_frames(TXD + 1, (TXD + 1) * 40 + 60);
    for (int i = 0; i < TXD + 1 && mon_q.size() > 0; i++) begin
      checks++; if (mon_q[0] !== {1'b1, sent[i], 1'b0}) begin
        errors++; $display("FAIL b2b_frame %0d: got %b want %b", i, mon_q[0], {1'b1, sent[i], 1'b0}); end
      $display("b2b frame %0d byte %h", i, sent[i]);
      void'(mon_q.pop_front());
    end
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra frames want 0", mon_q.size()); end
    repeat (10) step();
    rd(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL b2b_idle_stat: got %h want 0", d); end
    mon_en = 1'b0;
  endtask

  task automatic test_rx();
    logic [7:0] model[$];
    logic [31:0] d;
    logic [7:0] b;
    int div;
    wr(A_DIV, 16);
    send_rx(8'hA3, 16, 1'b1);
    repeat (8) step();
    rd(A_STAT, d); checks++; if (d !== 32'h04) begin errors++; $display("FAIL rx_valid: got %h want 04", d); end
    rd(A_RX, d);   checks++; if (d !== 32'hA3) begin errors++; $display("FAIL rx_a3: got %h want a3", d); end
    rd(A_STAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_drained: got %h want 0", d); end
    rd(A_RX, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_rd: got %h want 0", d); end
    div = 8 + 4 * $urandom_range(0, 2);
    wr(A_DIV, div);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom); model.push_back(b);
      send_rx(b, div, 1'b1);
    end
    repeat (8) step();
    while (model.size() > 0) begin
      rd(A_RX, d);
      checks++; if (d !== {24'h0, model[0]}) begin errors++; $display("FAIL rx_rand: got %h want %h", d, model[0]); end
      $display("rx byte %h at div %0d", d[7:0], div);
      void'(model.pop_front());
    end
    rd(A_STAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_rand_stat: got %h want 0", d); end
  endtask

  task automatic test_rx_errors();
    logic [7:0] model[$];
    logic [31:0] d;
    logic [7:0] b;
    wr(A_DIV, 16);
    uart_rx = 1'b0; repeat (2) step(); uart_rx = 1'b1; repeat (40) step();
    rd(A_STAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_glitch: got %h want 0", d); end
    send_rx(8'($urandom), 16, 1'b0);
    repeat (8) step();
    rd(A_STAT, d); checks++; if (d !== 32'h10) begin errors++; $display("FAIL rx_frame_err: got %h want 10", d); end
    wr(A_STAT, 32'h10);
    rd(A_STAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_ferr_clear: got %h want 0", d); end
    b = 8'($urandom);
    send_rx(b, 16, 1'b1); repeat (8) step();
    rd(A_RX, d); checks++; if (d !== {24'h0, b}) begin errors++; $display("FAIL rx_rearm: got %h want %h", d, b); end
    wr(A_DIV, 8);
    for (int i = 0; i < RXD + 1; i++) begin
      b = 8'($urandom);
      if (i < RXD) model.push_back(b);
      send_rx(b, 8, 1'b1);
    end
    repeat (8) step();
    rd(A_STAT, d); checks++; if (d !== 32'h0C) begin errors++; $display("FAIL rx_overrun: got %h want 0c", d); end
    while (model.size() > 0) begin
      rd(A_RX, d);
      checks++; if (d !== {24'h0, model[0]}) begin errors++; $display("FAIL rx_ovr_data: got %h want %h", d, model[0]); end
      $display("rx kept byte %h", d[7:0]);
      void'(model.pop_front());
    end
    rd(A_RX, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_ovr_empty: got %h want 0", d); end
    rd(A_STAT, d); checks++; if (d !== 32'h08) begin errors++; $display("FAIL rx_ovr_sticky: got %h want 08", d); end
    wr(A_STAT, 32'h08);
    rd(A_STAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_ovr_clear: got %h want 0", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
`ifdef UART_LOOPBACK_EN
    int t;
    wr(A_CTRL, 1);
    rd(A_CTRL, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_rd: got %h want 1", d); end
    uart_rx = 1'b0;
    wr(A_DIV, 4);
    wr(A_TX, 32'h3C);
    t = 0; d = '0;
    while (d[2] !== 1'b1 && t < 300) begin rd(A_STAT, d); t++; end
    checks++; if (d[2] !== 1'b1) begin errors++; $display("FAIL loopback_timeout: stat %h want bit2 set", d); end
    rd(A_RX, d); checks++; if (d !== 32'h3C) begin errors++; $display("FAIL loopback_data: got %h want 3c", d); end
    $display("loopback byte %h", d[7:0]);
    uart_rx = 1'b1;
    wr(A_CTRL, 0);
`else
    wr(A_CTRL, 1);
    rd(A_CTRL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_absent: got %h want 0", d); end
`endif
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    mon_en = 1'b0;
    repeat (12) step();
    wr(A_LED, 32'hA5);
    wr(A_DIV, 16);
    send_rx(8'h5A, 16, 1'b1); repeat (8) step();
    wr(A_DIV, 8);
    wr(A_TX, 32'h00); wr(A_TX, 32'hFF);
    repeat (20) step();
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b want 0", uart_tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", uart_tx); end
    step(); rst_n = 1'b1; step();
    rd(A_STAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_stat: got %h want 0", d); end
    rd(A_RX, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_rx: got %h want 0", d); end
    rd(A_DIV, d);  checks++; if (d !== RST_DIV) begin errors++; $display("FAIL midreset_div: got %h want %h", d, RST_DIV); end
    rd(A_LED, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_led: got %h want 0", d); end
    for (int i = 0; i < 100; i++) begin
      step();
      if (uart_tx !== 1'b1) begin
        checks++; errors++; $display("FAIL midreset_idle: got %b want 1 at cycle %0d", uart_tx, i); break;
      end
    end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midreset_final: got %b want 1", uart_tx); end
    $display("reset mid-frame checked");
  endtask

  initial begin
    test_reset();
    test_led();
    test_div();
    test_tx_frame();
    test_tx_random();
    test_div_midframe();
    test_back_to_back();
    test_rx();
    test_rx_errors();
    test_loopback();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
